// File: rtl/spu32_sram_ctrl.sv
// Asynchronous 16-bit SRAM controller: one access per request, fixed strobe timing, tag echoed on completion.
// Optional build macro SPU32_SRAM_CTRL_READ_LANE_MASK_EN zeroes disabled byte lanes of captured read data.
module spu32_sram_ctrl #(
   parameter int SRAM_ADDR_BITS = 18,
   parameter int WAIT_STATES    = 1
) (
   input  logic                      I_clk,
   input  logic                      I_reset_n,
   input  logic [3:0]                I_request,
   input  logic [SRAM_ADDR_BITS-1:0] I_addr,
   input  logic [15:0]               I_data,
   input  logic                      I_we,
   input  logic                      I_ub,
   input  logic                      I_lb,
   output logic [15:0]               O_data,
   output logic [3:0]                O_ack,
   output logic                      O_stall,
   output logic [SRAM_ADDR_BITS-1:0] O_sram_addr,
   output logic [15:0]               O_sram_dq,
   input  logic [15:0]               I_sram_dq,
   output logic                      O_sram_dq_oe,
   output logic                      O_sram_ce_n,
   output logic                      O_sram_oe_n,
   output logic                      O_sram_we_n,
   output logic                      O_sram_ub_n,
   output logic                      O_sram_lb_n
);

   typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, ACK} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

   state_t     state;
   logic [2:0] wait_cnt;
   logic [3:0] req_q;

`ifdef SPU32_SRAM_CTRL_READ_LANE_MASK_EN
   // Lane enables arrive as the active-low strobes already latched for this access.
   function automatic logic [15:0] lane_mask(input logic [15:0] dq, input logic ub_n, input logic lb_n);
      lane_mask = {(ub_n ? 8'h00 : dq[15:8]), (lb_n ? 8'h00 : dq[7:0])};
   endfunction
`endif

   always_ff @(posedge I_clk) begin
      if (!I_reset_n) begin
         state        <= IDLE;
         wait_cnt     <= 3'd0;
         O_ack        <= 4'd0;
         O_stall      <= 1'b1;
         O_sram_dq_oe <= 1'b0;
         O_sram_ce_n  <= 1'b1;
         O_sram_oe_n  <= 1'b1;
         O_sram_we_n  <= 1'b1;
         O_sram_ub_n  <= 1'b1;
         O_sram_lb_n  <= 1'b1;
         O_data       <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               O_ack   <= 4'd0;
               O_stall <= 1'b1;
               if (I_request != 4'd0) begin
                  req_q       <= I_request;
                  O_sram_addr <= I_addr;
                  O_sram_dq   <= I_data;
                  O_sram_ub_n <= ~I_ub;
                  O_sram_lb_n <= ~I_lb;
                  O_sram_ce_n <= 1'b0;
                  O_sram_we_n <= 1'b1;
                  wait_cnt    <= WAIT_INIT;
                  if (!I_we) begin
                     state        <= RD;
                     O_sram_oe_n  <= 1'b0;
                     O_sram_dq_oe <= 1'b0;
                  end else begin
                     state        <= WS;
                     O_sram_oe_n  <= 1'b1;
                     O_sram_dq_oe <= 1'b1;
                  end
               end
            end
            RD: begin
               if (wait_cnt == 3'd0) begin
`ifdef SPU32_SRAM_CTRL_READ_LANE_MASK_EN
                  O_data <= lane_mask(I_sram_dq, O_sram_ub_n, O_sram_lb_n);
`else
                  O_data <= I_sram_dq;
`endif
                  state       <= ACK;
                  O_sram_ce_n <= 1'b0 | 1'b1;
                  O_sram_oe_n <= 1'b1;
                  O_ack       <= req_q;
                  O_stall     <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            WS: begin
               state       <= WP;
               O_sram_we_n <= 1'b0;
               wait_cnt    <= WAIT_INIT;
            end
            WP: begin
               if (wait_cnt == 3'd0) begin
                  state       <= WH;
                  O_sram_we_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            WH: begin
               state        <= ACK;
               O_sram_ce_n  <= 1'b1;
               O_sram_dq_oe <= 1'b0;
               O_ack        <= req_q;
               O_stall      <= 1'b0;
            end
            ACK: begin
               state   <= IDLE;
               O_ack   <= 4'd0;
               O_stall <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               O_ack        <= 4'd0;
               O_stall      <= 1'b1;
               O_sram_dq_oe <= 1'b0;
               O_sram_ce_n  <= 1'b1;
               O_sram_oe_n  <= 1'b1;
               O_sram_we_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spu32_sram_ctrl.sv
// Directed bench for spu32_sram_ctrl at WAIT_STATES=1: vector table plus chained-read and mid-write reset sequences.
module tb_spu32_sram_ctrl;

   logic        I_clk = 1'b0;
   logic        I_reset_n;
   logic [3:0]  I_request;
   logic [17:0] I_addr;
   logic [15:0] I_data;
   logic        I_we, I_ub, I_lb;
   logic [15:0] O_data;
   logic [3:0]  O_ack;
   logic        O_stall;
   logic [17:0] O_sram_addr;
   logic [15:0] O_sram_dq;
   logic [15:0] I_sram_dq;
   logic        O_sram_dq_oe, O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_ub_n, O_sram_lb_n;

   int checks = 0;
   int errors = 0;

   spu32_sram_ctrl #(.SRAM_ADDR_BITS(18), .WAIT_STATES(1)) dut (
      .I_clk(I_clk), .I_reset_n(I_reset_n), .I_request(I_request), .I_addr(I_addr),
      .I_data(I_data), .I_we(I_we), .I_ub(I_ub), .I_lb(I_lb), .O_data(O_data),
      .O_ack(O_ack), .O_stall(O_stall), .O_sram_addr(O_sram_addr), .O_sram_dq(O_sram_dq),
      .I_sram_dq(I_sram_dq), .O_sram_dq_oe(O_sram_dq_oe), .O_sram_ce_n(O_sram_ce_n),
      .O_sram_oe_n(O_sram_oe_n), .O_sram_we_n(O_sram_we_n), .O_sram_ub_n(O_sram_ub_n),
      .O_sram_lb_n(O_sram_lb_n)
   );

   always #5 I_clk = ~I_clk;

   typedef struct {
      logic        we;
      logic [3:0]  tag;
      logic [17:0] addr;
      logic [15:0] wdata;
      logic        ub;
      logic        lb;
      logic [15:0] rd;
      logic [15:0] exp_data;
      int          lat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   lat, oe_lo, we_lo, dqoe_hi;
      bit   ctl_ok, pins_ok;
      v = vecs[i];
      lat = 0; oe_lo = 0; we_lo = 0; dqoe_hi = 0; ctl_ok = 1; pins_ok = 1;
      I_request = v.tag; I_addr = v.addr; I_data = v.wdata; I_we = v.we;
      I_ub = v.ub; I_lb = v.lb; I_sram_dq = v.rd;
      @(posedge I_clk);
      #1;
      // Junk on the request inputs mid-access must be ignored.
      I_request = 4'h5; I_addr = '1; I_data = 16'h0; I_we = ~v.we; I_ub = ~v.ub; I_lb = ~v.lb;
      for (int c = 1; c <= 20; c++) begin
         @(negedge I_clk);
         if (O_sram_addr !== v.addr || O_sram_ub_n !== ~v.ub || O_sram_lb_n !== ~v.lb) pins_ok = 0;
         if (O_ack !== 4'd0) begin
            lat = c;
            break;
         end
         if (O_stall !== 1'b1 || O_sram_ce_n !== 1'b0) ctl_ok = 0;
         if (v.we && O_sram_dq !== v.wdata) pins_ok = 0;
         if (O_sram_oe_n === 1'b0) oe_lo++;
         if (O_sram_we_n === 1'b0) we_lo++;
         if (O_sram_dq_oe === 1'b1) dqoe_hi++;
      end
      I_request = 4'd0;
      chk($sformatf("v%0d_latency", i), lat, v.lat);
      chk($sformatf("v%0d_ack_tag", i), int'(O_ack), int'(v.tag));
      chk($sformatf("v%0d_ack_stall", i), int'(O_stall), 0);
      chk($sformatf("v%0d_data", i), int'(O_data), int'(v.exp_data));
      chk($sformatf("v%0d_oe_low_cycles", i), oe_lo, v.we ? 0 : 2);
      chk($sformatf("v%0d_we_low_cycles", i), we_lo, v.we ? 2 : 0);
      chk($sformatf("v%0d_dq_oe_cycles", i), dqoe_hi, v.we ? 4 : 0);
      chk($sformatf("v%0d_ctl_during", i), int'(ctl_ok), 1);
      chk($sformatf("v%0d_pins_during", i), int'(pins_ok), 1);
      @(negedge I_clk);
      chk($sformatf("v%0d_post_ack", i), int'(O_ack), 0);
      chk($sformatf("v%0d_post_stall", i), int'(O_stall), 1);
      chk($sformatf("v%0d_data_hold", i), int'(O_data), int'(v.exp_data));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ack[8];
      exp_ack = '{0, 0, 'hB, 0, 0, 0, 6, 0};

      vecs[0] = '{1'b0, 4'h1, 18'h00010, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF, 3};
      vecs[1] = '{1'b1, 4'hA, 18'h3FFFF, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 5};
`ifdef SPU32_SRAM_CTRL_READ_LANE_MASK_EN
      vecs[2] = '{1'b0, 4'h3, 18'h00123, 16'h0000, 1'b0, 1'b1, 16'hA55A, 16'h005A, 3};
      vecs[3] = '{1'b0, 4'hF, 18'h2AAAA, 16'h0000, 1'b1, 1'b0, 16'h1357, 16'h1300, 3};
      vecs[4] = '{1'b1, 4'h7, 18'h15555, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h1300, 5};
      vecs[5] = '{1'b0, 4'h2, 18'h00001, 16'h0000, 1'b0, 1'b0, 16'hCAFE, 16'h0000, 3};
`else
      vecs[2] = '{1'b0, 4'h3, 18'h00123, 16'h0000, 1'b0, 1'b1, 16'hA55A, 16'hA55A, 3};
      vecs[3] = '{1'b0, 4'hF, 18'h2AAAA, 16'h0000, 1'b1, 1'b0, 16'h1357, 16'h1357, 3};
      vecs[4] = '{1'b1, 4'h7, 18'h15555, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h1357, 5};
      vecs[5] = '{1'b0, 4'h2, 18'h00001, 16'h0000, 1'b0, 1'b0, 16'hCAFE, 16'hCAFE, 3};
`endif
      vecs[6] = '{1'b0, 4'h8, 18'h00000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 3};

      I_reset_n = 1'b0; I_request = 4'd0; I_addr = '0; I_data = '0;
      I_we = 1'b0; I_ub = 1'b0; I_lb = 1'b0; I_sram_dq = 16'h0;
      repeat (3) @(negedge I_clk);
      chk("rst_ack", int'(O_ack), 0);
      chk("rst_stall", int'(O_stall), 1);
      chk("rst_dq_oe", int'(O_sram_dq_oe), 0);
      chk("rst_strobes", int'({O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_ub_n, O_sram_lb_n}), 'h1F);
      chk("rst_data", int'(O_data), 0);
      I_reset_n = 1'b1;
      repeat (2) @(negedge I_clk);
      chk("idle_stall", int'(O_stall), 1);

      for (int i = 0; i < 7; i++) run_vec(i);

      // Chained reads: second request held asserted through the first ACK.
      I_request = 4'hB; I_we = 1'b0; I_ub = 1'b1; I_lb = 1'b1; I_addr = 18'h00040; I_sram_dq = 16'h1111;
      @(posedge I_clk);
      #1 I_request = 4'h6;
      for (int c = 1; c <= 8; c++) begin
         @(negedge I_clk);
         chk($sformatf("chain_ack_c%0d", c), int'(O_ack), exp_ack[c-1]);
         chk($sformatf("chain_stall_c%0d", c), int'(O_stall), (exp_ack[c-1] != 0) ? 0 : 1);
         if (c == 3) begin
            chk("chain_data1", int'(O_data), 'h1111);
            I_sram_dq = 16'h2222;
         end
         if (c == 5) I_request = 4'd0;
         if (c == 7) chk("chain_data2", int'(O_data), 'h2222);
      end

      // Reset during the second write-pulse cycle.
      I_request = 4'h9; I_we = 1'b1; I_addr = 18'h00077; I_data = 16'h5555; I_ub = 1'b1; I_lb = 1'b1;
      @(posedge I_clk);
      #1 I_request = 4'd0;
      repeat (3) @(negedge I_clk);
      chk("mid_wp_we_low", int'(O_sram_we_n), 0);
      I_reset_n = 1'b0;
      @(negedge I_clk);
      chk("mid_rst_we_n", int'(O_sram_we_n), 1);
      chk("mid_rst_dq_oe", int'(O_sram_dq_oe), 0);
      chk("mid_rst_ce_n", int'(O_sram_ce_n), 1);
      chk("mid_rst_ack", int'(O_ack), 0);
      chk("mid_rst_stall", int'(O_stall), 1);
      chk("mid_rst_data", int'(O_data), 0);
      I_reset_n = 1'b1;
      @(negedge I_clk);
      run_vec(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spu32_sram_ctrl.md
SPU32_SRAM_CTRL -- requirements
Module: spu32_sram_ctrl

Interface
REQ-001 Parameter SRAM_ADDR_BITS, default 18: SRAM word-address width.
REQ-002 Parameter WAIT_STATES, default 1, legal 0..7: extra cycles added to each read and write strobe.
REQ-003 I_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 I_reset_n  in  1  synchronous, active-low reset.
REQ-005 I_request  in  4  request tag; 0 = none; bit3 = further words follow.
REQ-006 I_addr  in  SRAM_ADDR_BITS  word address.
REQ-007 I_data  in  16  write data.
REQ-008 I_we  in  1  1 = write, 0 = read.
REQ-009 I_ub / I_lb  in  1 each  upper/lower byte-lane enable, active high.
REQ-010 O_data  out  16  read data.
REQ-011 O_ack  out  4  completion tag.
REQ-012 O_stall  out  1  1 = no completion this cycle.
REQ-013 O_sram_addr  out  SRAM_ADDR_BITS  SRAM address pins.
REQ-014 O_sram_dq / I_sram_dq / O_sram_dq_oe  out/in/out  16/16/1  split data bus plus drive enable for the external tristate.
REQ-015 O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_ub_n, O_sram_lb_n  out  1 each  active-low SRAM strobes.

Function
REQ-016 FSM states: IDLE, RD, WS, WP, WH, ACK.
REQ-017 In IDLE with I_request!=0, SHALL latch request, addr, data, we, ub, lb at the clock edge; go to RD if I_we=0, else WS.
REQ-018 In IDLE with I_request=0, SHALL remain in IDLE.
REQ-019 RD: ce_n=0, oe_n=0, dq_oe=0 for WAIT_STATES+1 cycles; I_sram_dq captured into O_data at the last RD edge; then go to ACK.
REQ-020 WS: one cycle, ce_n=0, dq_oe=1, we_n=1. This is the address/data setup cycle.
REQ-021 WP: WAIT_STATES+1 cycles with ce_n=0, we_n=0, dq_oe=1.
REQ-022 WH: one cycle, we_n=1, dq_oe=1, data held; then go to ACK.
REQ-023 ACK: exactly one cycle, O_ack=latched tag, O_stall=0; then go to IDLE.
REQ-024 O_ack SHALL be 0 in every state except ACK.
REQ-025 O_stall SHALL be 1 in every state except ACK, including IDLE.
REQ-026 Latency from IDLE sample edge to ACK cycle:
- read: WAIT_STATES+2 cycles; with default 1 the ACK is 3 cycles after the sample.
- write: WAIT_STATES+4 cycles.
REQ-027 O_sram_addr, O_sram_dq, ub_n=~ub and lb_n=~lb SHALL be driven from the latched values, constant from sample edge through ACK.
REQ-028 I_request changes during an access SHALL be ignored; the access completes and acks.
REQ-029 A latched request with ub=lb=0 SHALL still run the full sequence with both lane strobes high, and ack.
REQ-030 O_data SHALL hold its value until the next read capture; writes do not alter it.
REQ-031 Back-to-back: a new request is sampled no earlier than the IDLE cycle following ACK.

Reset
REQ-032 On a clock edge with I_reset_n=0, from any state including mid-access, the block SHALL:
- go to IDLE;
- set O_ack=0, O_stall=1, dq_oe=0;
- drive all SRAM strobes high and O_data=0;
- clear the wait counter.

Configuration
REQ-033 Macro SPU32_SRAM_CTRL_READ_LANE_MASK_EN.
- Defined: read-data bytes whose lane enable was 0 SHALL be captured as 0x00.
- Undefined: all 16 bits are captured as driven on I_sram_dq.

Verification
REQ-034 WAIT_STATES=1; read, tag 4'h1, addr 0x00010, SRAM returns 0xBEEF -> oe_n low for 2 cycles; O_ack=4'h1, O_stall=0 exactly 3 cycles after sample; O_data=0xBEEF.
REQ-035 Write, tag 4'hA, addr 0x3FFFF, data 0x1234, ub=1, lb=0 -> WS 1 cycle, we_n low 2 cycles, ub_n=0, lb_n=1, dq_oe high 4 cycles, ack 4'hA on the 5th cycle.
REQ-036 Chained reads, tags 4'hB then 4'h6 -> two ACK pulses, O_stall=0 only in each ACK cycle, IDLE cycle between them.
REQ-037 Reset asserted during second WP cycle -> next edge: we_n=1, dq_oe=0, ce_n=1, O_ack=0, O_stall=1; a subsequent request completes normally.
REQ-038 Read, ub=0, lb=1, SRAM returns 0xA55A -> O_data=0x005A with macro defined, 0xA55A without.
